// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: self-test engine that sweeps every (A,B) operand pair into a magnitude comparator and checks gt/eq/lt.
// Latency: SETTLE+2 cycles per pair, done 2^(2W)*(SETTLE+2)+1 edges after start; optional first-failure log via CMP_SWEEP_LOG_EN.
// Backpressure: none; start is ignored while a sweep is running, cmp_* are only read in SAMPLE.
module cmp_sweep_driver #(
  parameter int W      = 2,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic [W-1:0] op_a,
  output logic [W-1:0] op_b,
  input  logic         cmp_gt,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [15:0]  err_count
`ifdef CMP_SWEEP_LOG_EN
  ,
  output logic [W-1:0] first_err_a,
  output logic [W-1:0] first_err_b,
  output logic         first_err_vld
`endif
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    exp_res;
  logic [2:0]    cut_res;
  logic          last_pair;

  assign exp_res   = {op_a > op_b, op_a == op_b, op_a < op_b};
  assign cut_res   = {cmp_gt, cmp_eq, cmp_lt};
  assign last_pair = &{op_a, op_b};

  // Status outputs are registered from the current state, so they trail the state by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      wait_cnt      <= '0;
      op_a          <= '0;
      op_b          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= 16'd0;
`ifdef CMP_SWEEP_LOG_EN
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_vld <= 1'b0;
`endif
    end else begin
      busy <= (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);
      done <= (state == S_DONE);
      pass <= (state == S_DONE) && (err_count == 16'd0);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_DRIVE;
            op_a          <= '0;
            op_b          <= '0;
            err_count     <= 16'd0;
            done          <= 1'b0;
            pass          <= 1'b0;
`ifdef CMP_SWEEP_LOG_EN
            first_err_a   <= '0;
            first_err_b   <= '0;
            first_err_vld <= 1'b0;
`endif
          end
        end
        S_DRIVE: begin
          wait_cnt <= '0;
          state    <= (SETTLE > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_SAMPLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          // Any deviation counts, including non-one-hot results.
          if (cut_res != exp_res) begin
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
`ifdef CMP_SWEEP_LOG_EN
            if (!first_err_vld) begin
              first_err_a   <= op_a;
              first_err_b   <= op_b;
              first_err_vld <= 1'b1;
            end
`endif
          end
          if (last_pair) begin
            state <= S_DONE;
          end else begin
            {op_a, op_b} <= {op_a, op_b} + 1'b1;
            state        <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
